// File: rtl/router_pkg.sv
// Shared packet layout constants and hop-field helpers for the router input port.
package router_pkg;

  localparam int HOP_MSB_DEF = 55;
  localparam int HOP_LSB_DEF = 48;
  localparam int PKT_W_DEF   = 64;
  localparam int PKT_MAX_W   = 256;

  typedef logic [PKT_W_DEF-1:0] pkt_t;
  typedef logic [PKT_MAX_W-1:0] pkt_wide_t;

  // Helpers work on a wide container so any DATA_WIDTH up to PKT_MAX_W can use them.
  function automatic pkt_wide_t hop_mask(input int msb, input int lsb);
    return ((pkt_wide_t'(1) << (msb - lsb + 1)) - pkt_wide_t'(1)) << lsb;
  endfunction

  function automatic pkt_wide_t hop_get(input pkt_wide_t p, input int msb, input int lsb);
    return (p & hop_mask(msb, lsb)) >> lsb;
  endfunction

  // Field wraps inside its own width; bits outside the field pass through.
  function automatic pkt_wide_t hop_dec(input pkt_wide_t p, input int msb, input int lsb);
    pkt_wide_t m;
    m = hop_mask(msb, lsb);
    return (p & ~m) | (((hop_get(p, msb, lsb) - pkt_wide_t'(1)) << lsb) & m);
  endfunction

endpackage

// File: rtl/router_input_port_if.sv
// Upstream link + arbiter side bundle of the router input port.
// Optional ROUTER_IN_STATS_EN adds the per-VC pop counters.
interface router_input_port_if #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_VC     = 2,
  parameter int VCW        = $clog2(NUM_VC)
);
  logic                         si;
  logic [VCW-1:0]               si_vc;
  logic [DATA_WIDTH-1:0]        di;
  logic [NUM_VC-1:0]            ri;
  logic [VCW-1:0]               rd_phase;
  logic [NUM_VC-1:0]            req_fwd;
  logic [NUM_VC-1:0]            req_pe;
  logic [NUM_VC-1:0]            gnt_fwd;
  logic [NUM_VC-1:0]            gnt_pe;
  logic [NUM_VC*DATA_WIDTH-1:0] dout_fwd;
  logic [NUM_VC*DATA_WIDTH-1:0] dout_pe;
  logic                         ovf_err;
`ifdef ROUTER_IN_STATS_EN
  logic [NUM_VC*16-1:0]         pkt_cnt;

  modport master (output si, si_vc, di, rd_phase, gnt_fwd, gnt_pe,
                  input  ri, req_fwd, req_pe, dout_fwd, dout_pe, ovf_err, pkt_cnt);
  modport slave  (input  si, si_vc, di, rd_phase, gnt_fwd, gnt_pe,
                  output ri, req_fwd, req_pe, dout_fwd, dout_pe, ovf_err, pkt_cnt);
`else
  modport master (output si, si_vc, di, rd_phase, gnt_fwd, gnt_pe,
                  input  ri, req_fwd, req_pe, dout_fwd, dout_pe, ovf_err);
  modport slave  (input  si, si_vc, di, rd_phase, gnt_fwd, gnt_pe,
                  output ri, req_fwd, req_pe, dout_fwd, dout_pe, ovf_err);
`endif
endinterface

// File: rtl/router_vc_fifo.sv
// Single virtual-channel circular FIFO, first-word-fall-through head, zero when empty.
module router_vc_fifo #(
  parameter  int DATA_WIDTH = 64,
  parameter  int DEPTH      = 4,
  localparam int PW         = $clog2(DEPTH),
  localparam int CW         = PW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic [CW-1:0]         count_o,
  output logic                  full_o,
  output logic                  empty_o
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  push_ok, pop_ok;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_q];

  // Acceptance looks only at the start-of-cycle count, so a same-cycle pop never frees room.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok) wr_d = wr_q + PW'(1);
    if (pop_ok)  rd_d = rd_q + PW'(1);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/router_input_port.sv
// Router input port: NUM_VC FIFOs, hop-based steering to forward/PE outputs, sticky overflow.
// Optional ROUTER_IN_STATS_EN adds saturating per-VC pop counters on pkt_cnt.
module router_input_port
  import router_pkg::*;
#(
  parameter  int DATA_WIDTH = PKT_W_DEF,
  parameter  int NUM_VC     = 2,
  parameter  int FIFO_DEPTH = 4,
  parameter  int HOP_MSB    = HOP_MSB_DEF,
  parameter  int HOP_LSB    = HOP_LSB_DEF,
  localparam int VCW        = $clog2(NUM_VC),
  localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input logic                clk,
  input logic                rst,
  router_input_port_if.slave bus
);
  logic [NUM_VC-1:0]                 push, pop, full, empty;
  logic [NUM_VC-1:0]                 req_fwd, req_pe, ri;
  logic [NUM_VC-1:0][DATA_WIDTH-1:0] head, head_fwd;
  logic [NUM_VC-1:0][CW-1:0]         count;
  logic                              ovf_q, ovf_d;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    logic act, hop_nz;

    assign push[v] = bus.si && (bus.si_vc == VCW'(v));
    assign act     = ~empty[v] && (bus.rd_phase == VCW'(v));
    assign hop_nz  = (hop_get(pkt_wide_t'(head[v]), HOP_MSB, HOP_LSB) != '0);

    assign req_fwd[v] = act & hop_nz;
    assign req_pe[v]  = act & ~hop_nz;
    // Grants only count against the direction actually requested.
    assign pop[v]     = (bus.gnt_fwd[v] & req_fwd[v]) | (bus.gnt_pe[v] & req_pe[v]);
    assign ri[v]      = (count[v] < CW'(FIFO_DEPTH));

    assign head_fwd[v] = empty[v] ? '0
                       : DATA_WIDTH'(hop_dec(pkt_wide_t'(head[v]), HOP_MSB, HOP_LSB));

    router_vc_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push[v]),
      .pop_i   (pop[v]),
      .din_i   (bus.di),
      .head_o  (head[v]),
      .count_o (count[v]),
      .full_o  (full[v]),
      .empty_o (empty[v])
    );
  end

  assign bus.req_fwd  = req_fwd;
  assign bus.req_pe   = req_pe;
  assign bus.ri       = ri;
  assign bus.dout_pe  = head;
  assign bus.dout_fwd = head_fwd;
  assign bus.ovf_err  = ovf_q;

  assign ovf_d = ovf_q | (|(push & full));

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

`ifdef ROUTER_IN_STATS_EN
  logic [NUM_VC-1:0][15:0] pkt_cnt_q, pkt_cnt_d;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    for (int v = 0; v < NUM_VC; v++) begin
      if (pop[v] && (pkt_cnt_q[v] != 16'hFFFF)) pkt_cnt_d[v] = pkt_cnt_q[v] + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pkt_cnt_q <= '0;
    else     pkt_cnt_q <= pkt_cnt_d;
  end

  assign bus.pkt_cnt = pkt_cnt_q;
`endif

endmodule

// File: doc/router_input_port.md
Name: router_input_port

Overview:
- Parametrised router input port: NUM_VC virtual channels, each a FIFO of FIFO_DEPTH entries.
- Each head packet is steered to the forward (ring) output or the local PE output, based on the hop field.
- Successor of the fixed 2-VC/8-entry channel input. Adds:
  - generic VC count and depth
  - per-VC ready
  - hop decrement on forwarded packets
  - overflow error flag
- Sits between the upstream link and the router's output arbiters.

Parameters:
- DATA_WIDTH, 64: packet width in bits.
- NUM_VC, 2: number of virtual channels, ≥2.
- FIFO_DEPTH, 4: entries per VC; power of two, ≥2.
- HOP_MSB, 55: MSB of the hop field.
- HOP_LSB, 48: LSB of the hop field.
- VCW, $clog2(NUM_VC): VC index width (derived; do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- si  in  1  upstream send strobe; packet valid on di this cycle.
- si_vc  in  VCW  target VC of the incoming packet.
- di  in  DATA_WIDTH  incoming packet.
- ri  out  NUM_VC  per-VC ready; ri[v]=1 when VC v has ≥1 free entry.
- rd_phase  in  VCW  VC allowed to request this cycle.
- req_fwd  out  NUM_VC  VC head requests the forward output.
- req_pe  out  NUM_VC  VC head requests the local PE output.
- gnt_fwd  in  NUM_VC  forward grant; pops the head of VC v.
- gnt_pe  in  NUM_VC  PE grant; pops the head of VC v.
- dout_fwd  out  NUM_VC*DATA_WIDTH  per-VC head packet with hop decremented; VC v occupies slice [v*DATA_WIDTH +: DATA_WIDTH].
- dout_pe  out  NUM_VC*DATA_WIDTH  per-VC head packet, unmodified.
- ovf_err  out  1  sticky overflow flag.

Behaviour:
- Reset (clk edge with rst=1):
  - all pointers and counts cleared
  - ri = all ones
  - req_fwd = req_pe = 0
  - dout_fwd = dout_pe = 0
  - ovf_err = 0
  - Reset mid-operation discards all buffered packets.
- Push:
  - si=1 and count[si_vc] < FIFO_DEPTH: di written at tail of si_vc; tail advances, wrapping mod FIFO_DEPTH.
  - Written packet is visible at the head at the earliest on the next cycle.
- Overflow:
  - si=1 with VC si_vc full: packet dropped, ovf_err set to 1 and held until rst.
  - A same-cycle pop does not rescue the push; acceptance uses the count at the start of the cycle.
- ri[v] is a combinational function of count[v] only (count[v] < FIFO_DEPTH), independent of grants.
- Request:
  - Active VC: count[v] > 0 and rd_phase == v.
  - Head hop field == 0: req_pe[v] = 1, req_fwd[v] = 0.
  - Head hop field != 0: req_fwd[v] = 1, req_pe[v] = 0.
  - Never both set. Requests are combinational from registered state plus rd_phase.
- Data outputs:
  - Head packet presented first-word-fall-through whenever count[v] > 0; zero when empty.
  - dout_fwd slice = head with the hop field decremented by 1; the field width is kept and the other bits are unchanged.
  - dout_pe slice = head unmodified.
- Pop:
  - gnt_fwd[v] & req_fwd[v], or gnt_pe[v] & req_pe[v], at a clk edge: head advances by one.
  - A grant without a matching request is ignored; no pop.
  - Both grants of one VC in one cycle: only the requested direction counts.
  - Zero-cycle latency from grant to pop; the next head or empty is visible the following cycle.
- Simultaneous push and pop on the same VC: count unchanged; both pointers advance.
- Pushes and pops on different VCs are fully independent in the same cycle.
- Pointers wrap at FIFO_DEPTH-1 → 0. count ranges 0..FIFO_DEPTH and needs $clog2(FIFO_DEPTH)+1 bits.

Optional Feature:
- Macro: ROUTER_IN_STATS_EN.
- Defined:
  - Adds output pkt_cnt, NUM_VC*16 bits: per-VC count of popped packets.
  - Each counter increments on every pop of its VC and saturates at 16'hFFFF.
  - Cleared by rst.
- Undefined: port and counters absent; all other behaviour identical.

Decomposition:
- Package router_pkg:
  - hop-field LSB/MSB default constants
  - packet typedef
  - hop-extract and hop-decrement functions
- Sub-module router_vc_fifo: one single-VC circular FIFO, instantiated NUM_VC times via generate.
  - Ports: push, pop, din, head, count, full, empty.
  - Top level holds request/steer logic, hop decrement, overflow flag and stats.

Test Plan:
- Reset, then push hop=3 packet 64'h0003_0000_0000_00AA to VC1, rd_phase=1 → next cycle req_fwd=2'b10; dout_fwd VC1 slice hop field=2, low byte AA; gnt_fwd[1] pops; VC1 empty next cycle.
- Push hop=0 packet to VC0 with rd_phase=1 → no request; switch rd_phase=0 → req_pe=2'b01 and dout_pe VC0 slice equals the pushed packet exactly.
- FIFO_DEPTH=4: push 4 packets to VC0 → ri[0]=0 with count 4; 5th push dropped, ovf_err=1; drain with 4 grants → packets in order, ri[0]=1; ovf_err remains 1.
- VC0 full, same-cycle si to VC0 and gnt_pe[0] → push dropped, ovf_err=1, count 3.
- VC0 holding 2, same-cycle push and pop on VC0 → count stays 2, FIFO order preserved across pointer wrap (run ≥8 such cycles).
- Grant to VC1 with no request, plus gnt_fwd and gnt_pe both asserted on a PE-bound head → only one pop; ignored grant changes nothing.
